axi3_mem_device: RTL and testbench

- Simulation/FPGA-model AXI3 slave memory: word-addressed RAM behind independent AXI3 read and write channel groups (the axi3_rd_if / axi3_wr_if bundles).
- Serves burst line refills for cache-side masters such as the stream buffer.
- RAM contents are preloadable by the bench through hierarchical access to instance "ram", array "mem".

---
 rtl/axi3_mem_device.sv | 201 ++++++++++++++++++++
 tb/tb_axi3_mem_device.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_mem_device.sv
// AXI3 slave memory model: a word-addressed byte-writable RAM served by
// independent read and write channel state machines.

module axi3_mem_device_ram #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data
);
    logic [DATA_WIDTH-1:0] mem [0:2**ADDR_WIDTH-1];

    // Read-before-write: a same-edge read of a word being written returns the old value.
    always_ff @(posedge clk) begin
        if (rd_en)
            rd_data <= mem[rd_addr];
        for (int i = 0; i < DATA_WIDTH/8; i++)
            if (wr_strb[i])
                mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
    end
endmodule

module axi3_mem_device #(
    parameter int BUS_WIDTH  = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUS_WIDTH-1:0]    arid,
    input  logic [31:0]             araddr,
    input  logic [3:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [BUS_WIDTH-1:0]    rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [BUS_WIDTH-1:0]    awid,
    input  logic [31:0]             awaddr,
    input  logic [3:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [BUS_WIDTH-1:0]    wid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [BUS_WIDTH-1:0]    bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic {R_IDLE, R_BURST} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

    rd_state_t rd_state, rd_next;
    wr_state_t wr_state, wr_next;

    logic [BUS_WIDTH-1:0]    rd_id, wr_id;
    logic [ADDR_WIDTH-1:0]   rd_idx, rd_idx_adv, wr_idx, wr_idx_adv;
    logic [4:0]              rd_count;
    logic [1:0]              rd_burst, wr_burst;
    logic                    ram_rd_en;
    logic [ADDR_WIDTH-1:0]   ram_rd_addr;
    logic [DATA_WIDTH/8-1:0] ram_wr_strb;

    // Size and beat-count fields plus out-of-range address bits carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{arsize, awsize, awlen, wid,
                             araddr[31:ADDR_WIDTH+2], araddr[1:0],
                             awaddr[31:ADDR_WIDTH+2], awaddr[1:0]};

    assign rd_idx_adv = (rd_burst == BURST_FIXED) ? rd_idx : rd_idx + 1'b1;
    assign wr_idx_adv = (wr_burst == BURST_FIXED) ? wr_idx : wr_idx + 1'b1;

    axi3_mem_device_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) ram (
        .clk     (clk),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (rdata),
        .wr_strb (ram_wr_strb),
        .wr_addr (wr_idx),
        .wr_data (wdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_state <= R_IDLE;
            wr_state <= W_IDLE;
        end else begin
            rd_state <= rd_next;
            wr_state <= wr_next;
        end
    end

    // The RAM is fetched one beat ahead so rdata is registered yet valid on entry to R_BURST.
    always_comb begin
        rd_next     = rd_state;
        ram_rd_en   = 1'b0;
        ram_rd_addr = rd_idx;
        case (rd_state)
            R_IDLE: begin
                if (arvalid) begin
                    rd_next     = R_BURST;
                    ram_rd_en   = 1'b1;
                    ram_rd_addr = araddr[ADDR_WIDTH+1:2];
                end
            end
            R_BURST: begin
                if (rready) begin
                    if (rd_count == 5'd1) begin
                        rd_next = R_IDLE;
                    end else begin
                        ram_rd_en   = 1'b1;
                        ram_rd_addr = rd_idx_adv;
                    end
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_id    <= '0;
            rd_idx   <= '0;
            rd_count <= '0;
            rd_burst <= '0;
        end else if (rd_state == R_IDLE && arvalid) begin
            rd_id    <= arid;
            rd_idx   <= araddr[ADDR_WIDTH+1:2];
            rd_count <= {1'b0, arlen} + 5'd1;
            rd_burst <= arburst;
        end else if (rd_state == R_BURST && rready) begin
            rd_idx   <= rd_idx_adv;
            rd_count <= rd_count - 5'd1;
        end
    end

    assign arready = (rd_state == R_IDLE);
    assign rvalid  = (rd_state == R_BURST);
    assign rlast   = (rd_state == R_BURST) && (rd_count == 5'd1);
    assign rid     = rd_id;
    assign rresp   = 2'b00;

    // wlast alone ends the write burst; awlen is not tracked.
    always_comb begin
        wr_next     = wr_state;
        ram_wr_strb = '0;
        case (wr_state)
            W_IDLE: if (awvalid) wr_next = W_DATA;
            W_DATA: begin
                if (wvalid) begin
                    ram_wr_strb = wstrb;
                    if (wlast)
                        wr_next = W_RESP;
                end
            end
            W_RESP: if (bready) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_id    <= '0;
            wr_idx   <= '0;
            wr_burst <= '0;
        end else if (wr_state == W_IDLE && awvalid) begin
            wr_id    <= awid;
            wr_idx   <= awaddr[ADDR_WIDTH+1:2];
            wr_burst <= awburst;
        end else if (wr_state == W_DATA && wvalid) begin
            wr_idx <= wr_idx_adv;
        end
    end

    assign awready = (wr_state == W_IDLE);
    assign wready  = (wr_state == W_DATA);
    assign bvalid  = (wr_state == W_RESP);
    assign bid     = wr_id;
    assign bresp   = 2'b00;
endmodule

// File: tb/tb_axi3_mem_device.sv
// Directed bench for axi3_mem_device: bursts, stalls, byte strobes, index wrap,
// mid-burst reset and concurrent read/write.

module tb_axi3_mem_device;
    localparam int DEPTH = 2**16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  arid, rid, awid, wid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axi3_mem_device dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int reset_cycles);
        arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        rst = 1'b0;
        repeat (reset_cycles) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic readBurst(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                             input logic [3:0] id, input bit toggle, input logic [31:0] exp [16]);
        int n = int'(len) + 1;
        int beats = 0;
        int cyc = 0;
        bit stalled = 0;
        bit rr;
        logic [31:0] held_data = '0;
        logic held_last = 1'b0;
        @(negedge clk);
        araddr = addr; arlen = len; arburst = burst; arid = id; arsize = 3'd2; arvalid = 1'b1;
        checkOutput("arready_idle", arready, 1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        checkOutput("first_beat_valid", rvalid, 1);
        checkOutput("arready_busy", arready, 0);
        while (beats < n && cyc < 100) begin
            rr = toggle ? (cyc % 2 == 0) : 1'b1;
            rready = rr;
            if (stalled) begin
                checkOutput("stall_rvalid", rvalid, 1);
                checkOutput("stall_rdata", rdata, held_data);
                checkOutput("stall_rlast", rlast, held_last);
            end
            if (rvalid) begin
                if (rr) begin
                    checkOutput($sformatf("rdata[%0d]", beats), rdata, exp[beats]);
                    checkOutput($sformatf("rid[%0d]", beats), rid, id);
                    checkOutput($sformatf("rlast[%0d]", beats), rlast, beats == n - 1);
                    checkOutput($sformatf("rresp[%0d]", beats), rresp, 0);
                    beats++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held_data = rdata;
                    held_last = rlast;
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        checkOutput("read_beats", beats, n);
        checkOutput("rvalid_done", rvalid, 0);
        checkOutput("arready_done", arready, 1);
    endtask

    task automatic writeBurst(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                              input logic [31:0] d [4], input logic [3:0] s [4]);
        int waits;
        @(negedge clk);
        awaddr = addr; awlen = len; awburst = 2'b01; awid = id; awsize = 3'd2; awvalid = 1'b1;
        checkOutput("awready_idle", awready, 1);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        checkOutput("awready_busy", awready, 0);
        for (int b = 0; b <= int'(len); b++) begin
            waits = 0;
            while (!wready && waits < 20) begin
                @(posedge clk);
                @(negedge clk);
                waits++;
            end
            checkOutput($sformatf("wready[%0d]", b), wready, 1);
            wvalid = 1'b1; wdata = d[b]; wstrb = s[b]; wid = id; wlast = (b == int'(len));
            @(posedge clk);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        checkOutput("wready_after_last", wready, 0);
        checkOutput("bvalid", bvalid, 1);
        checkOutput("bid", bid, id);
        checkOutput("bresp", bresp, 0);
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        checkOutput("bvalid_done", bvalid, 0);
        checkOutput("awready_done", awready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] e  [16];
        logic [31:0] d  [4];
        logic [3:0]  s  [4];
        logic [31:0] e2 [16];

        for (int i = 0; i < DEPTH; i++)
            dut.ram.mem[i] = 32'(i);
        dut.ram.mem[16] = 32'hAAAA_AAAA;
        dut.ram.mem[17] = 32'hAAAA_AAAA;

        applyStimulus(3);
        checkOutput("rst_arready", arready, 1);
        checkOutput("rst_awready", awready, 1);
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_rlast", rlast, 0);
        checkOutput("rst_wready", wready, 0);
        checkOutput("rst_bvalid", bvalid, 0);
        checkOutput("rst_resp", {rresp, bresp}, 0);
        rst = 1'b1;

        $display("[TB] 8-beat INCR read from 0x0");
        for (int i = 0; i < 16; i++) e[i] = 32'(i);
        readBurst(32'h0, 4'd7, 2'b01, 4'd2, 1'b0, e);

        $display("[TB] 8-beat read from 0x20 with rready toggling");
        for (int i = 0; i < 16; i++) e[i] = 32'(8 + i);
        readBurst(32'h20, 4'd7, 2'b01, 4'd5, 1'b1, e);

        $display("[TB] FIXED burst holds the index");
        for (int i = 0; i < 16; i++) e[i] = 32'd2;
        readBurst(32'h8, 4'd2, 2'b00, 4'd1, 1'b0, e);

        $display("[TB] 2-beat write with partial strobe at 0x40");
        d[0] = 32'hDEAD_BEEF; d[1] = 32'h1234_5678; d[2] = 0; d[3] = 0;
        s[0] = 4'hF; s[1] = 4'h3; s[2] = 0; s[3] = 0;
        writeBurst(32'h40, 4'd1, 4'd9, d, s);
        for (int i = 0; i < 16; i++) e[i] = 0;
        e[0] = 32'hDEAD_BEEF; e[1] = 32'hAAAA_5678;
        readBurst(32'h40, 4'd1, 2'b01, 4'd3, 1'b0, e);

        $display("[TB] read wrapping past the top of memory");
        for (int i = 0; i < 16; i++) e[i] = 0;
        e[0] = 32'(DEPTH - 2); e[1] = 32'(DEPTH - 1); e[2] = 32'd0; e[3] = 32'd1;
        readBurst(32'((DEPTH - 2) * 4), 4'd3, 2'b01, 4'd7, 1'b0, e);

        $display("[TB] reset during beat 3 of an 8-beat read");
        @(negedge clk);
        araddr = 32'h100; arlen = 4'd7; arburst = 2'b01; arid = 4'd4; arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        checkOutput("abort_beat1", rdata, 32'd64);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_beat2", rdata, 32'd65);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_beat3", rdata, 32'd66);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        checkOutput("abort_rvalid", rvalid, 0);
        checkOutput("abort_rlast", rlast, 0);
        checkOutput("abort_arready", arready, 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_rvalid_stays", rvalid, 0);
        rready = 1'b0;
        for (int i = 0; i < 16; i++) e[i] = 32'(i);
        readBurst(32'h0, 4'd1, 2'b01, 4'd6, 1'b0, e);

        $display("[TB] concurrent read and write to disjoint lines");
        for (int i = 0; i < 16; i++) e[i] = 32'(128 + i);
        d[0] = 32'h0101_0101; d[1] = 32'h2020_2020; d[2] = 32'h3333_0003; d[3] = 32'hC0FF_EE00;
        s[0] = 4'hF; s[1] = 4'hF; s[2] = 4'hF; s[3] = 4'hF;
        fork
            readBurst(32'h200, 4'd7, 2'b01, 4'd8, 1'b0, e);
            writeBurst(32'h300, 4'd3, 4'd11, d, s);
        join
        for (int i = 0; i < 16; i++) e2[i] = 0;
        e2[0] = 32'h0101_0101; e2[1] = 32'h2020_2020; e2[2] = 32'h3333_0003; e2[3] = 32'hC0FF_EE00;
        readBurst(32'h300, 4'd3, 2'b01, 4'd12, 1'b0, e2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
